mult_unit: RTL and testbench
============================

# mult_unit

Iterative 32×32 multiplier that executes the `mult`/`multu` requests issued by the decode stage and owns the architectural HI/LO registers read by `mfhi`/`mflo`. It sits in the execute stage beside the ALU. It accepts a one-cycle start strobe with signedness and two operands, then computes the 64-bit product with a shift-add loop. It raises `busy` so the hazard unit stalls any HI/LO reader or new multiply.

## Interface

Parameters:
- `WIDTH`, default 32: operand width; the product is 2×`WIDTH`.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-low (0 = reset).
- `multstartE`, input, 1: start strobe, sampled on the rising edge.
- `multsgnE`, input, 1: 1 selects `mult` (signed), 0 selects `multu`.
- `srcaE`, input, `WIDTH`: multiplicand (rs value, already forwarded).
- `srcbE`, input, `WIDTH`: multiplier (rt value, already forwarded).
- `busy`, output, 1: high while an operation is in progress.
- `done`, output, 1: one-cycle pulse in the cycle after HI/LO are written.
- `hi`, output, `WIDTH`: upper product register.
- `lo`, output, `WIDTH`: lower product register.

## Operation

- FSM states: IDLE, RUN, SIGN.
- IDLE:
  - On an edge with `multstartE`=1, latch `mcand` = |srcaE| (64 bits, zero-extended) and `mplier` = |srcbE| (32 bits).
  - Latch `neg` = multsgnE & (srcaE[31] ^ srcbE[31]); clear `acc`; set `count` = 0; go to RUN.
  - Magnitude is taken only when `multsgnE`=1; otherwise operands pass through unchanged.
  - |0x80000000| = 0x80000000, which is exact as an unsigned 32-bit value.
- RUN, each edge:
  - If mplier[0], then acc += mcand.
  - mcand <<= 1; mplier >>= 1; count++.
  - When count = 31 (the 32nd RUN edge), go to SIGN.
- SIGN, one edge: {hi, lo} ← neg ? −acc : acc (64-bit two's complement); go to IDLE.
- `busy` = (state ≠ IDLE), combinational.
- `done` is registered: it is set on the SIGN→IDLE edge and cleared on the following edge.
- HI/LO hold their previous value for the whole operation. They change only on the SIGN edge.
- `multstartE` while `busy` is ignored; no queuing. The hazard unit must stall the requester.
- Reset (asynchronous, any state, including mid-RUN) forces:
  - state = IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0;
  - `acc`, `mcand`, `mplier`, `count` = 0.
  - A partially computed product is discarded.
- All arithmetic is unsigned modulo 2^64; `acc` never overflows because the product fits in 64 bits.

## Timing

- Start accepted at edge E0. `busy` is high from E0 through E0+33. `hi`/`lo` are valid after edge E0+33. `done` is high during the cycle following E0+33.
- Fixed latency: 33 edges after acceptance (32 RUN + 1 SIGN), when `MULT_EARLY_TERM_EN` is not defined.
- Back-to-back: the earliest next start is the edge where `busy` reads 0 (E0+34).
- Reset deassertion: the first start can be accepted on the first rising edge with `reset`=1.

## Configuration

- `MULT_EARLY_TERM_EN` defined:
  - In RUN, leave for SIGN on any edge where the shifted `mplier` becomes 0, or count = 31.
  - RUN length = max(1, index of highest set bit of |srcbE| + 1) edges.
  - Example: srcbE=0 or 1 gives 1 RUN edge, so latency is 2.
  - The result is identical to the fixed-latency build.
- Not defined: always 32 RUN edges.

## Structure

- Package `mult_pkg` holds:
  - the state enum `mult_state_t` {IDLE, RUN, SIGN};
  - `MULT_W`=32 and `PROD_W`=64;
  - the RUN count terminal value 31.
- Sub-module `cond_neg #(W)`: combinational conditional two's-complement negate, y = n ? ~a+1 : a.
  - Used for both operand magnitudes (W=32).
  - Used for the final product (W=64).

## Test plan

- Reset mid-RUN:
  - Start 7×9, then assert `reset` low 10 cycles later → `busy`=0, `hi`=`lo`=0 immediately.
  - After release, a new 2×3 gives lo=6 at E0+33.
- `multu` 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, `done` pulse exactly 1 cycle at E0+34.
- `mult` −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; the same operands as `multu` → hi=0x00000004, lo=0xFFFFFFF1.
- `mult` 0x80000000 × 0x80000000 → hi=0x40000000, lo=0; then `mult` 0x80000000 × 1 → hi=0xFFFFFFFF, lo=0x80000000.
- Start strobe held high during `busy`:
  - Operands change mid-run → ignored; the first result is unaffected.
  - HI/LO keep their old values until E0+33.
- With `MULT_EARLY_TERM_EN`:
  - 12345 × 1 → `busy` for 2 cycles, lo=12345.
  - 6 × 0x00000100 → 9 RUN edges, lo=0x600.

Source files
------------

// File: rtl/mult_pkg.sv
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared types and constants for the iterative HI/LO multiplier.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int MULT_W   = 32;
    localparam int PROD_W   = 64;
    localparam int RUN_LAST = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } mult_state_t;

endpackage

`default_nettype wire

// File: rtl/cond_neg.sv
// ============================================================================
//  Module   : cond_neg
//  Purpose  : Combinational conditional two's-complement negate (y = n ? -a : a).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         n,
    output logic [W-1:0] y
);

    assign y = n ? (~a + W'(1)) : a;

endmodule

`default_nettype wire

// File: rtl/mult_unit.sv
// ============================================================================
//  Module   : mult_unit
//  Purpose  : Iterative shift-add mult/multu owning the HI/LO registers.
//             Define MULT_EARLY_TERM_EN to end the RUN loop once the
//             remaining multiplier bits are all zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multstartE,
    input  logic             multsgnE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W  = $clog2(WIDTH);
    localparam int LAST_I = (WIDTH == MULT_W) ? RUN_LAST : WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

    mult_state_t          state;
    mult_state_t          state_nxt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [CNT_W-1:0]     count;
    logic                 neg;
    logic                 run_last;

    cond_neg #(.W(WIDTH)) u_mag_a (
        .a (srcaE),
        .n (multsgnE & srcaE[WIDTH-1]),
        .y (mag_a)
    );

    cond_neg #(.W(WIDTH)) u_mag_b (
        .a (srcbE),
        .n (multsgnE & srcbE[WIDTH-1]),
        .y (mag_b)
    );

    cond_neg #(.W(2*WIDTH)) u_prod (
        .a (acc),
        .n (neg),
        .y (prod)
    );

`ifdef MULT_EARLY_TERM_EN
    // Stop once the shifted multiplier has no set bits left to add.
    assign run_last = (count == CNT_LAST) || (mplier[WIDTH-1:1] == '0);
`else
    assign run_last = (count == CNT_LAST);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (multstartE) state_nxt = RUN;
            RUN:     if (run_last)   state_nxt = SIGN;
            SIGN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == SIGN);
            case (state)
                IDLE: begin
                    if (multstartE) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        neg    <= multsgnE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                end
                SIGN: begin
                    {hi, lo} <= prod;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_unit.sv
// ============================================================================
//  Module   : tb_mult_unit
//  Purpose  : Self-checking bench for mult_unit against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        multstartE = 1'b0;
    logic        multsgnE = 1'b0;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .multstartE (multstartE),
        .multsgnE   (multsgnE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // Reference product straight from 64-bit integer arithmetic.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Edges from acceptance to the done pulse: RUN edges plus one SIGN edge.
    function automatic int exp_lat(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int          run;
        m = b;
        if (s && b[31]) m = 32'd0 - b;
`ifdef MULT_EARLY_TERM_EN
        run = 1;
        for (int i = 0; i < 32; i++) if (m[i]) run = i + 1;
`else
        run = 32;
        if (m == 32'hDEAD_BEEF) run = 32;
`endif
        return run + 1;
    endfunction

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        multstartE = 1'b1;
        srcaE      = a;
        srcbE      = b;
        multsgnE   = s;
        @(negedge clk);
        multstartE = 1'b0;
    endtask

    // Counts negedges until done is seen; -1 when the budget runs out.
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0",
                     busy, done, hi, lo);
        end
        reset = 1'b1;
    endtask

    task automatic test_directed;
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        logic        ts [7];
        logic [31:0] th [7];
        logic [31:0] tl [7];
        int          k;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; ts[0] = 0; th[0] = 32'hFFFF_FFFE; tl[0] = 32'h0000_0001;
        ta[1] = 32'hFFFF_FFFD; tb[1] = 32'd5;         ts[1] = 1; th[1] = 32'hFFFF_FFFF; tl[1] = 32'hFFFF_FFF1;
        ta[2] = 32'hFFFF_FFFD; tb[2] = 32'd5;         ts[2] = 0; th[2] = 32'h0000_0004; tl[2] = 32'hFFFF_FFF1;
        ta[3] = 32'h8000_0000; tb[3] = 32'h8000_0000; ts[3] = 1; th[3] = 32'h4000_0000; tl[3] = 32'h0000_0000;
        ta[4] = 32'h8000_0000; tb[4] = 32'd1;         ts[4] = 1; th[4] = 32'hFFFF_FFFF; tl[4] = 32'h8000_0000;
        ta[5] = 32'd12345;     tb[5] = 32'd1;         ts[5] = 0; th[5] = 32'd0;         tl[5] = 32'd12345;
        ta[6] = 32'd6;         tb[6] = 32'h0000_0100; ts[6] = 0; th[6] = 32'd0;         tl[6] = 32'h0000_0600;
        for (int t = 0; t < 7; t++) begin
            start_op(ta[t], tb[t], ts[t]);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL dir%0d_busy: busy=%b after start, required 1", t, busy);
            end
            wait_done(k);
            n_cmp++;
            if (k !== exp_lat(tb[t], ts[t])) begin
                n_fail++;
                $display("FAIL dir%0d_latency: done after %0d edges, required %0d",
                         t, k, exp_lat(tb[t], ts[t]));
            end
            n_cmp++;
            if (hi !== th[t] || lo !== tl[t] || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_result: hi=%h lo=%h busy=%b, required hi=%h lo=%h busy=0",
                         t, hi, lo, busy, th[t], tl[t]);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_done_width: done=%b one cycle later, required 0", t, done);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int k;
        start_op(32'd7, 32'd9, 1'b0);
        repeat (10) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        start_op(32'd2, 32'd3, 1'b0);
        wait_done(k);
        n_cmp++;
        if (k !== exp_lat(32'd3, 1'b0) || hi !== 32'd0 || lo !== 32'd6) begin
            n_fail++;
            $display("FAIL after_reset_op: lat=%0d hi=%h lo=%h, required lat=%0d hi=0 lo=6",
                     k, hi, lo, exp_lat(32'd3, 1'b0));
        end
    endtask

    task automatic test_start_held;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        logic [63:0] exp;
        int          k;
        a       = 32'h1234_5678;
        b       = 32'h9ABC_DEF0;
        exp     = ref_prod(a, b, 1'b1);
        prev_hi = hi;
        prev_lo = lo;
        multstartE = 1'b1;
        srcaE      = a;
        srcbE      = b;
        multsgnE   = 1'b1;
        @(negedge clk);
        k = -1;
        for (int i = 1; i <= 100; i++) begin
            srcaE    = $urandom;
            srcbE    = $urandom;
            multsgnE = 1'($urandom);
            @(negedge clk);
            if (done) begin
                k = i;
                multstartE = 1'b0;
                break;
            end
            n_cmp++;
            if (hi !== prev_hi || lo !== prev_lo) begin
                n_fail++;
                $display("FAIL held_hilo_stable: edge %0d hi=%h lo=%h, required hi=%h lo=%h",
                         i, hi, lo, prev_hi, prev_lo);
            end
        end
        multstartE = 1'b0;
        n_cmp++;
        if (k !== exp_lat(b, 1'b1) || {hi, lo} !== exp || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_result: lat=%0d hi_lo=%h busy=%b, required lat=%0d hi_lo=%h busy=0",
                     k, {hi, lo}, busy, exp_lat(b, 1'b1), exp);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_no_restart: busy=%b after release, required 0", busy);
        end
    endtask

    task automatic test_random;
        logic [31:0] edge_vals [6];
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
        int          k;
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'h0000_0001;
        edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h8000_0000;
        edge_vals[4] = 32'h7FFF_FFFF;
        edge_vals[5] = 32'h0000_00FF;
        for (int t = 0; t < 24; t++) begin
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            s   = 1'($urandom);
            exp = ref_prod(a, b, s);
            start_op(a, b, s);
            wait_done(k);
            n_cmp++;
            if (k !== exp_lat(b, s) || {hi, lo} !== exp) begin
                n_fail++;
                $display("FAIL rand%0d: a=%h b=%h sgn=%b lat=%0d hi_lo=%h, required lat=%0d hi_lo=%h",
                         t, a, b, s, k, {hi, lo}, exp_lat(b, s), exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          k;
        for (int t = 0; t < 3; t++) begin
            a   = 32'($urandom);
            b   = 32'($urandom) | 32'h8000_0000;
            exp = ref_prod(a, b, 1'b0);
            start_op(a, b, 1'b0);
            if (t > 0) begin
                n_cmp++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b%0d_accept: done=%b busy=%b, required done=0 busy=1",
                             t, done, busy);
                end
            end
            wait_done(k);
            n_cmp++;
            if (k !== exp_lat(b, 1'b0) || {hi, lo} !== exp) begin
                n_fail++;
                $display("FAIL b2b%0d_result: lat=%0d hi_lo=%h, required lat=%0d hi_lo=%h",
                         t, k, {hi, lo}, exp_lat(b, 1'b0), exp);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_run();
        test_start_held();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
